double_tokens: RTL and testbench

Serial token expander, the inverse of the token halver in the sequential-basics set. Every `1` token on input `a` produces two `1` tokens on output `b`. Tokens that cannot go out immediately are held in a bounded pending counter and drained one per cycle. A sticky `overflow` flag reports when that bound is exceeded. The block sits directly on a 1-bit serial token stream with no handshake.

---
 rtl/double_tokens.sv | 68 ++++++
 tb/tb_double_tokens.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/double_tokens.sv
// double_tokens: serial token expander, each a=1 token yields two b=1 tokens.
// Ports: clk, rst (sync, active-high), a (token in), b (token out), overflow (sticky).
// Define DOUBLE_TOKENS_REGISTERED_OUT_EN to drive b from a flop (1-cycle latency).
module double_tokens #(
  parameter int MAX_PENDING = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  output logic b,
  output logic overflow
);

  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam logic [PW-1:0] PMAX = PW'(MAX_PENDING);

  logic [PW-1:0] pending;
  logic [PW-1:0] pending_nx;
  logic          b_int;
  logic          drop;

  // One token leaves per cycle whenever anything is owed or arriving.
  always_comb begin
    b_int      = a | (pending != '0);
    drop       = 1'b0;
    pending_nx = pending;
    if (a) begin
      // Two in, one out: net +1, saturating at the bound.
      if (pending == PMAX) begin
        drop = 1'b1;
      end else begin
        pending_nx = pending + PW'(1);
      end
    end else if (pending != '0) begin
      pending_nx = pending - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= pending_nx;
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef DOUBLE_TOKENS_REGISTERED_OUT_EN
  logic b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      b_q <= 1'b0;
    end else begin
      b_q <= b_int;
    end
  end

  // Gate keeps b low in the reset cycle itself, not only after it.
  assign b = b_q & ~rst;
`else
  assign b = b_int & ~rst;
`endif

endmodule

// File: tb/tb_double_tokens.sv
// tb_double_tokens: scoreboard bench for double_tokens.
// Runs a default-bound instance and a MAX_PENDING=3 instance side by side.
module tb_double_tokens;

  localparam int MAXA = 200;
  localparam int MAXB = 3;

  logic clk;
  logic rst;
  logic a;
  logic b;
  logic b3;
  logic ovf;
  logic ovf3;

  int n_chk;
  int n_pass;
  int mp, mp3;
  int mov, mov3;
  int drop3;
  int na, nb, nb3;
  bit up;
  logic qb[$];
  logic qb3[$];

  double_tokens #(.MAX_PENDING(MAXA)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .overflow(ovf)
  );

  double_tokens #(.MAX_PENDING(MAXB)) dut3 (
    .clk(clk), .rst(rst), .a(a), .b(b3), .overflow(ovf3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic mdl(input logic av, input logic rv,
                     input int lim, inout int p, inout int ov, inout int dr);
    if (rv) begin
      p  = 0;
      ov = 0;
    end else if (av) begin
      if (p == lim) begin
        ov = 1;
        dr++;
      end else begin
        p++;
      end
    end else if (p > 0) begin
      p--;
    end
  endtask

  task automatic cyc(input logic av, input logic rv);
    logic e, e3, x, x3;
    int dd;
    dd = 0;
    a = av;
    rst = rv;
    e  = !rv && (av || mp != 0);
    e3 = !rv && (av || mp3 != 0);
    qb.push_back(e);
    qb3.push_back(e3);
    x  = qb.pop_front();
    x3 = qb3.pop_front();
    if (av && !rv) na++;
    @(negedge clk);
    chk("b", int'(b), int'(x & ~rv));
    chk("b3", int'(b3), int'(x3 & ~rv));
    if (up) begin
      chk("ovf", int'(ovf), mov);
      chk("ovf3", int'(ovf3), mov3);
    end
    nb  += int'(b);
    nb3 += int'(b3);
    @(posedge clk);
    mdl(av, rv, MAXA, mp, mov, dd);
    mdl(av, rv, MAXB, mp3, mov3, drop3);
    #1;
    up = 1'b1;
    chk("pend", int'(dut.pending), mp);
    chk("pend3", int'(dut3.pending), mp3);
  endtask

  task automatic seg(input logic [31:0] pat, input int len);
    for (int i = len - 1; i >= 0; i--) cyc(pat[i], 1'b0);
  endtask

  task automatic clr();
    na = 0;
    nb = 0;
    nb3 = 0;
    drop3 = 0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    mp = 0; mp3 = 0; mov = 0; mov3 = 0;
    up = 1'b0;
    a = 1'b0;
    rst = 1'b1;
    clr();
`ifdef DOUBLE_TOKENS_REGISTERED_OUT_EN
    qb.push_back(1'b0);
    qb3.push_back(1'b0);
`endif
    @(posedge clk);
    #1;
    // reset held 3 cycles with a=1, then idle
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
    clr();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    chk("rst_idle_b", nb, 0);

    clr();
    seg(32'b1000, 4);
    chk("single_cnt", nb, 2);

    clr();
    seg(32'b110000, 6);
    chk("burst_cnt", nb, 4);

    clr();
    seg(32'b110011100000, 12);
    chk("sparse_cnt", nb, 10);

    // overflow on the small instance: 5 in, 2 dropped, 8 out
    clr();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);
    chk("ovf3_pend", int'(dut3.pending), 3);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
    chk("ovf3_cnt", nb3, 8);
    chk("ovf3_drop", drop3, 2);
    chk("ovf3_sticky", int'(ovf3), 1);
    chk("ovf_big", int'(ovf), 0);

    // reset in mid-drain
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);
    chk("mid_pend", int'(dut.pending), 5);
    cyc(1'b0, 1'b1);
    chk("mid_pend0", int'(dut.pending), 0);
    clr();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
    chk("mid_b0", nb, 0);
    chk("mid_ovf3", int'(ovf3), 0);

    // random stream, density about 35%
    clr();
    for (int i = 0; i < 10000; i++) begin
      cyc(logic'($urandom_range(0, 99) < 35), 1'b0);
    end
    for (int i = 0; i < MAXA + 10; i++) cyc(1'b0, 1'b0);
    chk("rand_tok", nb, 2 * na);
    chk("rand_tok3", nb3, 2 * na - drop3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
